bt_uart_frame_tx: RTL and testbench

Serial transmitter for the Bluetooth UART link. It accepts a pre-assembled 11-bit frame (start, data, parity/extra, stop bits, already placed by upstream logic) on a write request. It shifts the frame out LSB-first on Tx at a programmable bit rate and reports busy/done status to the host-side controller.

---
 rtl/bt_uart_frame_tx.sv | 103 ++++++++++
 tb/tb_bt_uart_frame_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bt_uart_frame_tx.sv
// Bluetooth UART frame transmitter: shifts a pre-assembled frame out LSB-first
// on Tx at CLKS_PER_BIT clocks per bit, with registered busy/done status.
module bt_uart_frame_tx #(
  parameter int unsigned FRAME_BITS   = 11,
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAME_BITS-1:0] din,
  input  logic                  enable,
  input  logic                  RW,
  output logic                  Tx,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         baud_cnt, baud_cnt_n;
  logic [IW-1:0]         bit_idx, bit_idx_n;
  // din[0] goes straight to Tx at start, so only the remaining bits are held;
  // shreg[1] is always the next bit to send.
  logic [FRAME_BITS-1:1] shreg, shreg_n;
  logic                  tx_n, busy_n, done_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      Tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      Tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    tx_n       = Tx;
    busy_n     = busy;
    done_n     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (enable && RW) begin
          shreg_n    = din[FRAME_BITS-1:1];
          tx_n       = din[0];
          busy_n     = 1'b1;
          bit_idx_n  = '0;
          baud_cnt_n = '0;
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_n = '0;
          if (bit_idx == IDX_LAST) begin
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            tx_n      = shreg[1];
            shreg_n   = shreg >> 1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DONE: begin
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bt_uart_frame_tx.sv
// Directed bench for bt_uart_frame_tx: one instance at 1 clock/bit, one at
// 4 clocks/bit, outputs sampled on the falling clock edge.
module tb_bt_uart_frame_tx;

  logic        TB_clk = 1'b0;
  logic        rst_n;
  logic [10:0] din1, din4;
  logic        en1, rw1, en4, rw4;
  logic        tx1, done1, busy1;
  logic        tx4, done4, busy4;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  localparam logic [10:0] FRAME_A = 11'b10010101010;

  always #5 TB_clk = ~TB_clk;

  bt_uart_frame_tx #(.FRAME_BITS(11), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(TB_clk), .rst_n(rst_n), .din(din1), .enable(en1), .RW(rw1),
    .Tx(tx1), .done(done1), .busy(busy1)
  );

  bt_uart_frame_tx #(.FRAME_BITS(11), .CLKS_PER_BIT(4)) u_dut4 (
    .clk(TB_clk), .rst_n(rst_n), .din(din4), .enable(en4), .RW(rw4),
    .Tx(tx4), .done(done4), .busy(busy4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_idle1(input string tag);
    check_val({tag, "_tx1"}, tx1, 1'b1);
    check_val({tag, "_busy1"}, busy1, 1'b0);
    check_val({tag, "_done1"}, done1, 1'b0);
  endtask

  task automatic check_idle4(input string tag);
    check_val({tag, "_tx4"}, tx4, 1'b1);
    check_val({tag, "_busy4"}, busy4, 1'b0);
    check_val({tag, "_done4"}, done4, 1'b0);
  endtask

  // Called on the first falling edge after the accepting rising edge.
  task automatic expect_frame1(input logic [10:0] f);
    for (int i = 0; i < 11; i++) begin
      check_val("f1_tx", tx1, f[i]);
      check_val("f1_busy", busy1, 1'b1);
      check_val("f1_done", done1, 1'b0);
      @(negedge TB_clk);
    end
    check_val("f1_done_pulse", done1, 1'b1);
    check_val("f1_done_busy", busy1, 1'b0);
    check_val("f1_done_tx", tx1, 1'b1);
    @(negedge TB_clk);
    check_idle1("f1_after");
    @(negedge TB_clk);
  endtask

  // poke: drive a new din and a request mid-frame, which must be ignored.
  task automatic expect_frame4(input logic [10:0] f, input bit poke);
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (poke && i == 3 && j == 1) begin
          din4 = 11'h7FF; en4 = 1'b1; rw4 = 1'b1;
        end else if (poke && i == 3 && j == 2) begin
          en4 = 1'b0; rw4 = 1'b0;
        end
        check_val("f4_tx", tx4, f[i]);
        check_val("f4_busy", busy4, 1'b1);
        check_val("f4_done", done4, 1'b0);
        @(negedge TB_clk);
      end
    end
    check_val("f4_done_pulse", done4, 1'b1);
    check_val("f4_done_busy", busy4, 1'b0);
    check_val("f4_done_tx", tx4, 1'b1);
    @(negedge TB_clk);
    check_idle4("f4_after");
    @(negedge TB_clk);
  endtask

  initial begin
    rst_n = 1'b0;
    din1 = '0; din4 = '0;
    en1 = 1'b0; rw1 = 1'b0; en4 = 1'b0; rw4 = 1'b0;
    repeat (2) @(negedge TB_clk);
    check_idle1("rst");
    check_idle4("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge TB_clk);
    check_idle1("post_rst");
    check_idle4("post_rst");

    // Basic send, one clock per bit, single-cycle request
    din1 = FRAME_A; en1 = 1'b1; rw1 = 1'b1;
    @(negedge TB_clk);
    en1 = 1'b0; rw1 = 1'b0; din1 = '0;
    expect_frame1(FRAME_A);
    for (int k = 0; k < 3; k++) begin
      check_idle1("basic_tail");
      @(negedge TB_clk);
    end

    // Bit timing, four clocks per bit
    din4 = FRAME_A; en4 = 1'b1; rw4 = 1'b1;
    @(negedge TB_clk);
    en4 = 1'b0; rw4 = 1'b0;
    expect_frame4(FRAME_A, 1'b0);

    // Mid-frame din change and request are ignored; no second frame follows
    din4 = 11'b01100110011; en4 = 1'b1; rw4 = 1'b1;
    @(negedge TB_clk);
    en4 = 1'b0; rw4 = 1'b0;
    expect_frame4(11'b01100110011, 1'b1);
    for (int k = 0; k < 10; k++) begin
      check_idle4("ignore_tail");
      @(negedge TB_clk);
    end

    // Non-write requests do nothing
    din1 = 11'h000; en1 = 1'b1; rw1 = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(negedge TB_clk);
      check_idle1("rw0");
    end
    en1 = 1'b0; rw1 = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge TB_clk);
      check_idle1("en0");
    end
    rw1 = 1'b0;
    @(negedge TB_clk);

    // Back-to-back: held request restarts after one idle cycle
    din1 = 11'b00111000101; en1 = 1'b1; rw1 = 1'b1;
    @(negedge TB_clk);
    expect_frame1(11'b00111000101);
    expect_frame1(11'b00111000101);
    en1 = 1'b0; rw1 = 1'b0;
    expect_frame1(11'b00111000101);
    check_idle1("b2b_end");

    // Asynchronous reset mid-frame
    din4 = FRAME_A; en4 = 1'b1; rw4 = 1'b1;
    @(negedge TB_clk);
    en4 = 1'b0; rw4 = 1'b0;
    repeat (9) @(negedge TB_clk);
    check_val("pre_rst_busy4", busy4, 1'b1);
    check_val("pre_rst_tx4", tx4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_idle4("async_rst");
    @(negedge TB_clk);
    check_idle4("rst_hold");
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge TB_clk);
      check_idle4("rst_release");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
